// File: rtl/cache_refill_if.sv
// Signal bundle between the refill controller (slave) and its cache/memory environment (master).
// Handshakes: a request transfers when req_valid & req_ready on a rising edge; a writeback beat
// transfers when mem_wr_valid & mem_wr_ready; refill beats arrive when mem_rd_valid is high.
interface cache_refill_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        hit0;
  logic        hit1;
  logic        dirty0;
  logic        dirty1;
  logic        lru_replace;
  logic        lru_enable;
  logic        lru_target;
  logic [23:0] vic_tag;
  logic [31:0] vic_rdata;
  logic        arr_we;
  logic        arr_way;
  logic [1:0]  arr_word;
  logic [31:0] arr_wdata;
  logic        tag_we;
  logic        mem_rd_req;
  logic [31:0] mem_addr;
  logic        mem_rd_valid;
  logic [31:0] mem_rd_data;
  logic        mem_wr_valid;
  logic        mem_wr_ready;
  logic [31:0] mem_wr_data;
  logic        mem_wr_last;
  logic        resp_valid;
  logic        resp_way;

  modport slave (
    input  req_valid, req_addr, hit0, hit1, dirty0, dirty1, lru_replace,
           vic_tag, vic_rdata, mem_rd_valid, mem_rd_data, mem_wr_ready,
    output req_ready, lru_enable, lru_target, arr_we, arr_way, arr_word,
           arr_wdata, tag_we, mem_rd_req, mem_addr, mem_wr_valid, mem_wr_data,
           mem_wr_last, resp_valid, resp_way
  );

  modport master (
    output req_valid, req_addr, hit0, hit1, dirty0, dirty1, lru_replace,
           vic_tag, vic_rdata, mem_rd_valid, mem_rd_data, mem_wr_ready,
    input  req_ready, lru_enable, lru_target, arr_we, arr_way, arr_word,
           arr_wdata, tag_we, mem_rd_req, mem_addr, mem_wr_valid, mem_wr_data,
           mem_wr_last, resp_valid, resp_way
  );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Two-way cache miss handler: optional dirty-victim writeback, 4-beat line refill,
// then tag write, LRU update and response. Hits respond one cycle after accept.
module cache_refill_ctrl (
  input  logic              clk,
  input  logic              rst,
  cache_refill_if.slave     bus,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WB     = 3'd1,
    S_RD_REQ = 3'd2,
    S_REFILL = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_beat;
  logic        r_victim;
  logic [23:0] r_tag;
  logic [3:0]  r_index;
  logic [23:0] r_wb_tag;
  logic        r_wb_tag_ok;
  logic        r_hit_pulse;
  logic        r_hit_way;

  logic w_accept;
  logic w_hit;
  logic w_hit_way;
  logic w_victim_dirty;
  logic w_wr_fire;
  logic w_rd_fire;
  logic w_unused;

  assign w_accept       = bus.req_valid & bus.req_ready;
  assign w_hit          = bus.hit0 | bus.hit1;
  assign w_hit_way      = ~bus.hit0 & bus.hit1;
  assign w_victim_dirty = bus.lru_replace ? bus.dirty1 : bus.dirty0;
  assign w_wr_fire      = (r_state == S_WB) & bus.mem_wr_ready;
  assign w_rd_fire      = (r_state == S_REFILL) & bus.mem_rd_valid;
  assign w_unused       = &{1'b0, bus.req_addr[3:0]};
  assign o_dbg_state    = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept && !w_hit) w_next = w_victim_dirty ? S_WB : S_RD_REQ;
      S_WB:     if (w_wr_fire && r_beat == 2'd3) w_next = S_RD_REQ;
      S_RD_REQ: w_next = S_REFILL;
      S_REFILL: if (w_rd_fire && r_beat == 2'd3) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_beat      <= 2'd0;
      r_victim    <= 1'b0;
      r_tag       <= 24'd0;
      r_index     <= 4'd0;
      r_wb_tag    <= 24'd0;
      r_wb_tag_ok <= 1'b0;
      r_hit_pulse <= 1'b0;
      r_hit_way   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_hit_pulse <= w_accept & w_hit;
      if (w_accept && w_hit) r_hit_way <= w_hit_way;
      if (w_accept && !w_hit) begin
        r_tag    <= bus.req_addr[31:8];
        r_index  <= bus.req_addr[7:4];
        r_victim <= bus.lru_replace;
      end
      // Beat counter wraps 3->0, so it is already zeroed for the refill after a writeback.
      if (w_wr_fire || w_rd_fire) r_beat <= r_beat + 2'd1;
      // The victim tag is only visible once arr_way points at the victim, i.e. in the first WB cycle.
      if (r_state == S_WB && !r_wb_tag_ok) begin
        r_wb_tag    <= bus.vic_tag;
        r_wb_tag_ok <= 1'b1;
      end else if (r_state != S_WB) begin
        r_wb_tag_ok <= 1'b0;
      end
    end
  end

  always_comb begin
    bus.req_ready    = 1'b0;
    bus.lru_enable   = 1'b0;
    bus.lru_target   = 1'b0;
    bus.arr_we       = 1'b0;
    bus.arr_way      = 1'b0;
    bus.arr_word     = 2'd0;
    bus.arr_wdata    = 32'd0;
    bus.tag_we       = 1'b0;
    bus.mem_rd_req   = 1'b0;
    bus.mem_addr     = 32'd0;
    bus.mem_wr_valid = 1'b0;
    bus.mem_wr_data  = 32'd0;
    bus.mem_wr_last  = 1'b0;
    bus.resp_valid   = 1'b0;
    bus.resp_way     = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready  = rst;
        bus.resp_valid = r_hit_pulse;
        bus.resp_way   = r_hit_pulse & r_hit_way;
        bus.lru_enable = r_hit_pulse;
        bus.lru_target = r_hit_pulse & r_hit_way;
      end
      S_WB: begin
        bus.arr_way      = r_victim;
        bus.arr_word     = r_beat;
        bus.mem_wr_valid = 1'b1;
        bus.mem_wr_data  = bus.vic_rdata;
        bus.mem_wr_last  = (r_beat == 2'd3);
        bus.mem_addr     = {(r_wb_tag_ok ? r_wb_tag : bus.vic_tag), r_index, 4'b0000};
      end
      S_RD_REQ: begin
        bus.mem_rd_req = 1'b1;
        bus.mem_addr   = {r_tag, r_index, 4'b0000};
      end
      S_REFILL: begin
        bus.arr_way   = r_victim;
        bus.arr_word  = r_beat;
        bus.arr_we    = bus.mem_rd_valid;
        bus.arr_wdata = bus.mem_rd_data;
      end
      S_DONE: begin
        bus.arr_way    = r_victim;
        bus.tag_we     = 1'b1;
        bus.lru_enable = 1'b1;
        bus.lru_target = r_victim;
        bus.resp_valid = 1'b1;
        bus.resp_way   = r_victim;
      end
      default: begin
        bus.req_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: a small two-way single-set array model feeds vic_tag/vic_rdata,
// and every DUT output event is matched in order against a queue of bench-predicted events.
module tb_cache_refill_ctrl;

  localparam int W = 72;
  localparam logic [3:0] K_WB = 4'd1, K_RD = 4'd2, K_AW = 4'd3, K_TAG = 4'd4, K_LRU = 4'd5, K_RESP = 4'd6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [2:0] dbg_state;
  cache_refill_if bus();

  cache_refill_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // ---------------- environment: array model ----------------
  logic [23:0] tb_tag [2] = '{24'h111111, 24'hABCDEF};
  logic [31:0] tb_data [2][4] = '{'{32'hD000_0000, 32'hD000_0001, 32'hD000_0002, 32'hD000_0003},
                                  '{32'hD000_0100, 32'hD000_0101, 32'hD000_0102, 32'hD000_0103}};
  logic [23:0] cur_tag = 24'd0;

  assign bus.vic_tag   = tb_tag[bus.arr_way];
  assign bus.vic_rdata = tb_data[bus.arr_way][bus.arr_word];

  always @(posedge clk) begin
    if (bus.arr_we) tb_data[bus.arr_way][bus.arr_word] <= bus.arr_wdata;
    if (bus.tag_we) tb_tag[bus.arr_way] <= cur_tag;
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int accept_cyc = 0;
  int resp_cyc = 0;
  int last_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] ev(input logic [3:0] k, input logic [31:0] a,
                                      input logic [31:0] d, input logic [3:0] m);
    return {k, a, d, m};
  endfunction

  function automatic logic [W-1:0] outs();
    return {24'd0, bus.req_ready, bus.resp_valid, bus.resp_way, bus.lru_enable, bus.lru_target,
            bus.arr_we, bus.arr_way, bus.arr_word, bus.tag_we, bus.mem_rd_req, bus.mem_wr_valid,
            bus.mem_wr_last, dbg_state, (bus.mem_addr | bus.arr_wdata | bus.mem_wr_data)};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mon(input logic [W-1:0] obs);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_vec++;
      assert (exp_q.size() != 0) else begin
        n_err++;
        $error("FAIL unexpected_event: observed %h expected none", obs);
      end
    end else begin
      e = exp_q.pop_front();
      chk("event", obs, e);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (bus.req_valid && bus.req_ready) accept_cyc = cyc;
      if (bus.mem_wr_valid && bus.mem_wr_ready)
        mon(ev(K_WB, bus.mem_addr, bus.mem_wr_data, {3'b000, bus.mem_wr_last}));
      if (bus.mem_rd_req) mon(ev(K_RD, bus.mem_addr, 32'd0, 4'd0));
      if (bus.arr_we) mon(ev(K_AW, {29'd0, bus.arr_way, bus.arr_word}, bus.arr_wdata, 4'd0));
      if (bus.tag_we) mon(ev(K_TAG, {31'd0, bus.arr_way}, 32'd0, 4'd0));
      if (bus.lru_enable) mon(ev(K_LRU, {31'd0, bus.lru_target}, 32'd0, 4'd0));
      if (bus.resp_valid) begin
        mon(ev(K_RESP, {31'd0, bus.resp_way}, 32'd0, 4'd0));
        resp_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [31:0] addr, input logic h0, input logic h1, input logic way);
    exp_q.push_back(ev(K_LRU, {31'd0, way}, 32'd0, 4'd0));
    exp_q.push_back(ev(K_RESP, {31'd0, way}, 32'd0, 4'd0));
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.hit0 = h0; bus.hit1 = h1;
    bus.lru_replace = ~way; bus.dirty0 = 1'b1; bus.dirty1 = 1'b1;
    tick();
    bus.req_valid = 1'b0; bus.hit0 = 1'b0; bus.hit1 = 1'b0;
    tick();
    chk("hit_latency", resp_cyc - accept_cyc, 1);
  endtask

  task automatic miss(input logic [31:0] addr, input logic vic, input logic dirty,
                      input int stall, input int gap, input logic b2b);
    logic [31:0] rd [4];
    for (int b = 0; b < 4; b++) rd[b] = $urandom;
    if (dirty)
      for (int b = 0; b < 4; b++)
        exp_q.push_back(ev(K_WB, {tb_tag[vic], addr[7:4], 4'h0}, tb_data[vic][b], {3'b000, b == 3}));
    exp_q.push_back(ev(K_RD, {addr[31:4], 4'h0}, 32'd0, 4'd0));
    for (int b = 0; b < 4; b++) exp_q.push_back(ev(K_AW, {29'd0, vic, 2'(b)}, rd[b], 4'd0));
    exp_q.push_back(ev(K_TAG, {31'd0, vic}, 32'd0, 4'd0));
    exp_q.push_back(ev(K_LRU, {31'd0, vic}, 32'd0, 4'd0));
    exp_q.push_back(ev(K_RESP, {31'd0, vic}, 32'd0, 4'd0));
    cur_tag = addr[31:8];
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.hit0 = 1'b0; bus.hit1 = 1'b0;
    bus.lru_replace = vic;
    if (vic) begin bus.dirty1 = dirty; bus.dirty0 = ~dirty; end
    else begin bus.dirty0 = dirty; bus.dirty1 = ~dirty; end
    // Stray handshakes outside their states must be ignored.
    bus.mem_wr_ready = 1'b1; bus.mem_rd_valid = 1'b1; bus.mem_rd_data = 32'hDEAD_BEEF;
    tick();
    if (b2b) begin bus.req_addr = 32'h0000_0020; bus.hit1 = 1'b1; end
    else bus.req_valid = 1'b0;
    if (dirty) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 2 && stall > 0) begin
          bus.mem_wr_ready = 1'b0;
          repeat (stall) begin
            tick();
            chk("wb_stall_hold", {37'd0, bus.mem_wr_valid, bus.mem_wr_last, bus.mem_wr_data, dbg_state},
                {37'd0, 1'b1, 1'b0, tb_data[vic][2], 3'd1});
          end
          bus.mem_wr_ready = 1'b1;
        end
        tick();
      end
    end
    bus.mem_wr_ready = 1'b0;
    tick();
    for (int b = 0; b < 4; b++) begin
      if (gap > 0) begin bus.mem_rd_valid = 1'b0; repeat (gap) tick(); end
      bus.mem_rd_valid = 1'b1; bus.mem_rd_data = rd[b];
      tick();
    end
    bus.mem_rd_valid = 1'b0;
    tick();
    chk("miss_latency", resp_cyc - accept_cyc, 6 + (dirty ? 4 : 0) + stall + 4 * gap);
    last_done = resp_cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd0;
    bus.req_valid = 1'b0; bus.req_addr = 32'd0; bus.hit0 = 1'b0; bus.hit1 = 1'b0;
    bus.dirty0 = 1'b0; bus.dirty1 = 1'b0; bus.lru_replace = 1'b0;
    bus.mem_rd_valid = 1'b0; bus.mem_rd_data = 32'd0; bus.mem_wr_ready = 1'b0;
    #1;
    chk("reset_outputs", outs(), '0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1 chk("ready_after_reset", outs(), W'(1) << 47);
    tick();

    hit(32'h0000_0154, 1'b0, 1'b1, 1'b1);
    hit(32'h0000_0044, 1'b1, 1'b1, 1'b0);
    miss(32'h1234_5678, 1'b0, 1'b0, 0, 0, 1'b0);
    miss(32'h9876_5450, 1'b1, 1'b1, 3, 0, 1'b0);

    // Request held through a dirty miss is taken in the first IDLE cycle after DONE.
    miss(32'h0C0F_FE30, 1'b0, 1'b1, 0, 0, 1'b1);
    exp_q.push_back(ev(K_LRU, 32'd1, 32'd0, 4'd0));
    exp_q.push_back(ev(K_RESP, 32'd1, 32'd0, 4'd0));
    tick();
    bus.req_valid = 1'b0; bus.hit1 = 1'b0;
    tick();
    chk("b2b_accept_cycle", accept_cyc - last_done, 1);
    chk("b2b_hit_latency", resp_cyc - accept_cyc, 1);

    miss(32'h5555_5590, 1'b1, 1'b0, 0, 2, 1'b0);

    // Reset during refill, after beat 1.
    rd0 = $urandom;
    exp_q.push_back(ev(K_RD, 32'h0BAD_0120, 32'd0, 4'd0));
    exp_q.push_back(ev(K_AW, 32'd0, rd0, 4'd0));
    exp_q.push_back(ev(K_AW, 32'd1, rd0 ^ 32'h5A5A_5A5A, 4'd0));
    cur_tag = 24'h0BAD01;
    bus.req_valid = 1'b1; bus.req_addr = 32'h0BAD_0124; bus.lru_replace = 1'b0;
    bus.dirty0 = 1'b0; bus.dirty1 = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick();
    bus.mem_rd_valid = 1'b1; bus.mem_rd_data = rd0;
    tick();
    bus.mem_rd_data = rd0 ^ 32'h5A5A_5A5A;
    tick();
    bus.mem_rd_data = 32'h0123_4567;
    chk("refill_mid_state", {69'd0, dbg_state}, 72'd3);
    #2 rst = 1'b0;
    #1 chk("reset_async_zero", outs(), '0);
    tick();
    chk("reset_held_zero", outs(), '0);
    rst = 1'b1;
    #1 chk("ready_after_abort", outs(), W'(1) << 47);
    repeat (2) begin
      tick();
      chk("stray_rd_no_we", {71'd0, bus.arr_we}, '0);
    end
    bus.mem_rd_valid = 1'b0;
    hit(32'h0000_0088, 1'b1, 1'b0, 1'b0);

    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
